// File: rtl/inst_fetch.sv
// ----------------------------------------------------------------------------
// inst_fetch
//
// Purpose:
//   Instruction fetch stage. A PC register addresses an instruction memory
//   that returns data combinationally in the same cycle. Each fetched word is
//   pushed, together with its PC, into a 2-entry in-order queue that feeds
//   decode through a valid/ready handshake. A redirect from execute flushes
//   the queue and restarts fetch at the target. A misaligned target parks
//   the block in FAULT until reset.
//
// Parameters:
//   RESET_PC        PC loaded on reset (bits [1:0] must be 0)
//
// Ports:
//   i_clk           clock, all state updates on the rising edge
//   i_rst           synchronous active-high reset
//   o_mem_address   fetch address (the PC register itself)
//   o_mem_op_type   memory operation type, always 0 (read)
//   i_mem_val       memory read data for o_mem_address, same cycle
//   i_redirect      taken branch/jump request from execute
//   i_redirect_pc   redirect target, sampled when i_redirect=1
//   o_inst_valid    queue head holds a valid instruction for decode
//   o_inst          instruction word at the queue head (0 when empty)
//   o_inst_pc       address of o_inst (0 when empty)
//   i_inst_ready    decode accepts the head on a cycle with o_inst_valid=1
//   o_fault         misaligned redirect target seen; sticky until reset
// ----------------------------------------------------------------------------
module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   output logic [31:0] o_mem_address,
   output logic        o_mem_op_type,
   input  logic [31:0] i_mem_val,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   output logic        o_inst_valid,
   output logic [31:0] o_inst,
   output logic [31:0] o_inst_pc,
   input  logic        i_inst_ready,
   output logic        o_fault
);

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FAULT = 1'b1
   } state_e;

   state_e            state_q, state_d;
   logic [31:0]       pc_q, pc_d;
   logic [1:0]        count_q, count_d;
   // Entry 0 is always the head; a pop shifts entry 1 down into entry 0.
   logic [1:0][31:0]  q_inst_q, q_inst_d;
   logic [1:0][31:0]  q_pc_q, q_pc_d;

   logic              pop;
   logic [1:0]        fill;   // occupancy after this cycle's pop

   assign pop  = (state_q == ST_RUN) && (count_q != 2'd0) && i_inst_ready;
   assign fill = count_q - {1'b0, pop};

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      state_d  = state_q;
      pc_d     = pc_q;
      count_d  = count_q;
      q_inst_d = q_inst_q;
      q_pc_d   = q_pc_q;

      if (state_q == ST_RUN) begin
         if (i_redirect) begin
            // Flush wins over any push or pop this cycle.
            count_d = 2'd0;
            if (i_redirect_pc[1:0] != 2'b00) begin
               state_d = ST_FAULT;       // PC keeps its old value
            end else begin
               pc_d = i_redirect_pc;
            end
         end else begin
            if (pop) begin
               q_inst_d[0] = q_inst_q[1];
               q_pc_d[0]   = q_pc_q[1];
            end
            // Push whenever a slot is free once the pop has been accounted for.
            if (fill != 2'd2) begin
               q_inst_d[fill[0]] = i_mem_val;
               q_pc_d[fill[0]]   = pc_q;
               pc_d              = pc_q + 32'd4;   // wraps modulo 2^32
               count_d           = fill + 2'd1;
            end else begin
               count_d = fill;
            end
         end
      end
   end

   // NOTE: state is registered with non-blocking assignments so every flop
   // samples the pre-edge values computed above.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         // NOTE: the queue storage is cleared on reset as well, not just the
         // count, so the entry contents come up as a known zero.
         state_q  <= ST_RUN;
         pc_q     <= RESET_PC;
         count_q  <= 2'd0;
         q_inst_q <= '0;
         q_pc_q   <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         count_q  <= count_d;
         q_inst_q <= q_inst_d;
         q_pc_q   <= q_pc_d;
      end
   end

   assign o_mem_address = pc_q;
   assign o_mem_op_type = 1'b0;
   assign o_inst_valid  = (state_q == ST_RUN) && (count_q != 2'd0);
   assign o_inst        = (count_q != 2'd0) ? q_inst_q[0] : 32'h0;
   assign o_inst_pc     = (count_q != 2'd0) ? q_pc_q[0]   : 32'h0;
   assign o_fault       = (state_q == ST_FAULT);

endmodule

// File: tb/tb_inst_fetch.sv
// ----------------------------------------------------------------------------
// tb_inst_fetch
//
// Self-checking bench for inst_fetch. The instruction memory returns
// address ^ 32'hA5A5_0000. A queue-based model of the fetch stage is stepped
// on every rising edge and compared against the DUT outputs on every falling
// edge; directed scenarios add literal expectations on top.
// ----------------------------------------------------------------------------
module tb_inst_fetch;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] KEY      = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        i_rst = 1'b1;
   logic [31:0] o_mem_address;
   logic        o_mem_op_type;
   logic [31:0] i_mem_val;
   logic        i_redirect = 1'b0;
   logic [31:0] i_redirect_pc = 32'h0;
   logic        o_inst_valid;
   logic [31:0] o_inst;
   logic [31:0] o_inst_pc;
   logic        i_inst_ready = 1'b0;
   logic        o_fault;

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;

   inst_fetch #(.RESET_PC(RESET_PC)) dut (
      .i_clk         (clk),
      .i_rst         (i_rst),
      .o_mem_address (o_mem_address),
      .o_mem_op_type (o_mem_op_type),
      .i_mem_val     (i_mem_val),
      .i_redirect    (i_redirect),
      .i_redirect_pc (i_redirect_pc),
      .o_inst_valid  (o_inst_valid),
      .o_inst        (o_inst),
      .o_inst_pc     (o_inst_pc),
      .i_inst_ready  (i_inst_ready),
      .o_fault       (o_fault)
   );

   always #5 clk = ~clk;

   // Combinational instruction memory.
   assign i_mem_val = o_mem_address ^ KEY;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] m_pc;
   logic [31:0] mq[$];     // fetched PCs, head first
   bit          m_fault = 1'b0;
   bit          m_init  = 1'b0;

   always @(posedge clk) begin
      if (i_rst) begin
         m_pc    = RESET_PC;
         mq.delete();
         m_fault = 1'b0;
         m_init  = 1'b1;
      end else if (m_init && !m_fault) begin
         if (i_redirect) begin
            mq.delete();
            if (i_redirect_pc[1:0] != 2'b00) m_fault = 1'b1;
            else                             m_pc    = i_redirect_pc;
         end else begin
            if (mq.size() > 0 && i_inst_ready) void'(mq.pop_front());
            if (mq.size() < 2) begin
               mq.push_back(m_pc);
               m_pc = m_pc + 32'd4;
            end
         end
      end
   end

   // Delivered stream as seen at the DUT boundary.
   logic [31:0] del_pc[$];
   logic [31:0] del_inst[$];

   function automatic logic [31:0] del_at(input int i);
      return (del_pc.size() > i) ? del_pc[i] : 32'hDEAD_BEEF;
   endfunction

   function automatic logic [31:0] del_inst_at(input int i);
      return (del_inst.size() > i) ? del_inst[i] : 32'hDEAD_BEEF;
   endfunction

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (m_init) begin
         logic        e_valid;
         logic [31:0] e_pc, e_inst;
         e_valid = !m_fault && (mq.size() > 0);
         e_pc    = (mq.size() > 0) ? mq[0] : 32'h0;
         e_inst  = (mq.size() > 0) ? (mq[0] ^ KEY) : 32'h0;
         check("cmp_valid",   {31'h0, o_inst_valid},  {31'h0, e_valid});
         check("cmp_inst",    o_inst,                 e_inst);
         check("cmp_inst_pc", o_inst_pc,              e_pc);
         check("cmp_mem_addr", o_mem_address,         m_pc);
         check("cmp_op_type", {31'h0, o_mem_op_type}, 32'h0);
         check("cmp_fault",   {31'h0, o_fault},       {31'h0, m_fault});
      end
      if (o_inst_valid && i_inst_ready && !i_redirect && !i_rst) begin
         del_pc.push_back(o_inst_pc);
         del_inst.push_back(o_inst);
      end
   end

   task automatic cyc(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic clear_del();
      del_pc.delete();
      del_inst.delete();
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      // Reset state.
      i_rst = 1'b1;
      cyc(2);
      check("rst_valid",   {31'h0, o_inst_valid}, 32'h0);
      check("rst_inst",    o_inst,                32'h0);
      check("rst_inst_pc", o_inst_pc,             32'h0);
      check("rst_fault",   {31'h0, o_fault},      32'h0);
      check("rst_mem_addr", o_mem_address,        RESET_PC);
      check("rst_op_type", {31'h0, o_mem_op_type}, 32'h0);

      // Streaming with decode always ready: 0,4,8,12 back to back.
      i_inst_ready = 1'b1;
      i_rst        = 1'b0;
      clear_del();
      cyc(1);
      check("first_valid", {31'h0, o_inst_valid}, 32'h1);
      check("first_pc",    o_inst_pc,             RESET_PC);
      cyc(5);
      for (int i = 0; i < 4; i++) begin
         check("stream_pc",   del_at(i),      32'(i * 4));
         check("stream_inst", del_inst_at(i), 32'(i * 4) ^ KEY);
      end

      // Back-pressure: queue saturates at two, PC holds at 8.
      i_rst = 1'b1;
      cyc(1);
      i_rst        = 1'b0;
      i_inst_ready = 1'b0;
      cyc(5);
      check("bp_mem_addr", o_mem_address,         32'h8);
      check("bp_inst_pc",  o_inst_pc,             32'h0);
      check("bp_valid",    {31'h0, o_inst_valid}, 32'h1);
      clear_del();
      i_inst_ready = 1'b1;
      cyc(3);
      check("bp_rel_0", del_at(0), 32'h0);
      check("bp_rel_1", del_at(1), 32'h4);
      check("bp_rel_2", del_at(2), 32'h8);

      // Redirect with 8,C in the queue: both are flushed.
      i_rst = 1'b1;
      cyc(1);
      i_rst        = 1'b0;
      i_inst_ready = 1'b0;
      cyc(3);
      i_inst_ready = 1'b1;
      cyc(2);
      check("pre_redir_head", o_inst_pc, 32'h8);
      clear_del();
      i_redirect    = 1'b1;
      i_redirect_pc = 32'h100;
      cyc(1);
      i_redirect = 1'b0;
      check("redir_gap_valid", {31'h0, o_inst_valid}, 32'h0);
      cyc(1);
      check("redir_valid", {31'h0, o_inst_valid}, 32'h1);
      check("redir_pc",    o_inst_pc,             32'h100);
      check("redir_inst",  o_inst,                32'h100 ^ KEY);
      cyc(1);
      check("redir_del_first", del_at(0), 32'h100);

      // Misaligned redirect: fault is sticky, later redirects ignored.
      i_redirect    = 1'b1;
      i_redirect_pc = 32'h102;
      cyc(1);
      check("fault_set",   {31'h0, o_fault},      32'h1);
      check("fault_valid", {31'h0, o_inst_valid}, 32'h0);
      check("fault_pc",    o_mem_address,         32'h108);
      i_redirect_pc = 32'h200;
      cyc(1);
      i_redirect = 1'b0;
      check("fault_hold",    {31'h0, o_fault}, 32'h1);
      check("fault_ign_pc",  o_mem_address,    32'h108);
      cyc(2);
      check("fault_still_invalid", {31'h0, o_inst_valid}, 32'h0);
      i_rst = 1'b1;
      cyc(1);
      check("fault_clr",     {31'h0, o_fault}, 32'h0);
      check("fault_rst_pc",  o_mem_address,    RESET_PC);

      // Wrap at the top of the address space.
      i_rst         = 1'b0;
      i_redirect    = 1'b1;
      i_redirect_pc = 32'hFFFF_FFFC;
      cyc(1);
      i_redirect = 1'b0;
      clear_del();
      cyc(3);
      check("wrap_pc_0",   del_at(0),      32'hFFFF_FFFC);
      check("wrap_pc_1",   del_at(1),      32'h0000_0000);
      check("wrap_inst_1", del_inst_at(1), 32'hA5A5_0000);

      // Reset wins over a redirect while the queue is full.
      i_inst_ready = 1'b0;
      cyc(3);
      check("full_valid", {31'h0, o_inst_valid}, 32'h1);
      i_rst         = 1'b1;
      i_redirect    = 1'b1;
      i_redirect_pc = 32'h300;
      cyc(1);
      check("rr_mem_addr", o_mem_address,         RESET_PC);
      check("rr_valid",    {31'h0, o_inst_valid}, 32'h0);
      check("rr_inst",     o_inst,                32'h0);
      check("rr_inst_pc",  o_inst_pc,             32'h0);
      check("rr_fault",    {31'h0, o_fault},      32'h0);
      i_rst        = 1'b0;
      i_redirect   = 1'b0;
      i_inst_ready = 1'b1;
      cyc(1);
      check("rr_first_valid", {31'h0, o_inst_valid}, 32'h1);
      check("rr_first_pc",    o_inst_pc,             RESET_PC);
      cyc(2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC loaded on reset; bits [1:0] must be 0.
REQ-002 i_clk  input  1  SHALL be the clock; all state updates on its rising edge.
REQ-003 i_rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 o_mem_address  output  32  SHALL carry the fetch address to the instruction memory.
REQ-005 o_mem_op_type  output  1  SHALL be the memory operation type and SHALL be constant 0 (read).
REQ-006 i_mem_val  input  32  SHALL be the memory read data, valid combinationally for o_mem_address in the same cycle.
REQ-007 i_redirect  input  1  SHALL be the taken branch/jump request from execute.
REQ-008 i_redirect_pc  input  32  SHALL be the redirect target, sampled when i_redirect=1.
REQ-009 o_inst_valid  output  1  SHALL flag that o_inst/o_inst_pc hold a valid instruction for decode.
REQ-010 o_inst  output  32  SHALL be the instruction word at the queue head.
REQ-011 o_inst_pc  output  32  SHALL be the address of o_inst.
REQ-012 i_inst_ready  input  1  SHALL be the decode-side acceptance; a transfer occurs on a cycle where o_inst_valid=1 and i_inst_ready=1.
REQ-013 o_fault  output  1  SHALL flag a misaligned redirect target.

Function
REQ-014 The block SHALL hold a PC register, a 2-entry instruction queue (word + PC per entry), a 2-bit occupancy count, and a state register with states RUN and FAULT.
REQ-015 o_mem_address SHALL equal the PC register directly (no added latency).
REQ-016 Push: in RUN, with no redirect, when count<2 or a pop occurs in the same cycle, the block SHALL write {i_mem_val, PC} to the queue tail and set PC <= PC+4.
REQ-017 PC+4 SHALL be modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0000_0000).
REQ-018 Pop: a transfer (REQ-012) SHALL remove the head entry; with count=0, i_inst_ready SHALL have no effect.
REQ-019 Simultaneous push and pop with count=2 SHALL leave count=2 with entries in order; with count=1 it SHALL leave count=1.
REQ-020 With count=2 and no pop, the block SHALL not push and PC SHALL hold.
REQ-021 o_inst_valid SHALL be 1 iff count>0 and state=RUN; o_inst/o_inst_pc SHALL show the head entry, and SHALL be 0 when the queue is empty.
REQ-022 Redirect in RUN with i_redirect_pc[1:0]=0: at the edge, the queue SHALL be flushed (count=0), PC <= i_redirect_pc, no push; any pop that cycle SHALL be discarded with the flush.
REQ-023 Redirect latency: the target instruction SHALL be pushed on the following edge, so o_inst_valid=1 with o_inst_pc=target one cycle after the redirect edge.
REQ-024 Redirect in RUN with i_redirect_pc[1:0]!=0: state SHALL go to FAULT, the queue SHALL be flushed, PC SHALL hold the old value, and o_fault SHALL become 1.
REQ-025 In FAULT: no push, no pop, o_inst_valid=0, o_fault=1, i_redirect ignored; only reset SHALL leave FAULT.
REQ-026 Instruction order to decode SHALL equal fetch order; no entry is duplicated or dropped except by flush.

Reset
REQ-027 While i_rst=1 at an edge: PC <= RESET_PC, count <= 0, state <= RUN, queue contents <= 0; reset SHALL override redirect, push and pop in the same cycle.
REQ-028 After reset: o_inst_valid=0, o_inst=0, o_inst_pc=0, o_fault=0, o_mem_address=RESET_PC, o_mem_op_type=0.
REQ-029 Reset asserted mid-operation (queue full or FAULT) SHALL produce the REQ-028 state on the next edge.
REQ-030 First instruction SHALL appear (o_inst_valid=1, o_inst_pc=RESET_PC) one edge after i_rst deasserts.

Verification
REQ-031 Reset, i_inst_ready=1, memory word at addr A = A^32'hA5A5_0000 -> stream PCs 0,4,8,... one per cycle, o_inst matches memory, no gaps.
REQ-032 i_inst_ready=0 for 5 cycles after reset -> count saturates at 2, o_mem_address holds 8, o_inst_pc=0; release -> PCs 0,4,8 delivered in order.
REQ-033 Redirect to 32'h100 while queue holds PCs 8,C, i_inst_ready=1 -> next cycle o_inst_valid=0; the cycle after, o_inst_pc=32'h100, 8/C never delivered.
REQ-034 Redirect to 32'h102 -> o_fault=1, o_inst_valid=0, later redirect to 32'h200 ignored; i_rst=1 -> o_fault=0, o_mem_address=RESET_PC.
REQ-035 Redirect to 32'hFFFF_FFFC -> PCs FFFF_FFFC then 0000_0000 delivered consecutively.
REQ-036 i_rst=1 together with i_redirect=1 while full -> REQ-028 state, PC=RESET_PC not target.
